// File: rtl/sonyimx_sync_sequencer.sv
// Sony IMX sub-LVDS frame/line timing: SAV / active / EAV / h-blank words per slot.
// Optional SONYIMX_TEST_PATTERN_EN replaces upstream pixels with a per-lane ramp.

module sonyimx_sync_lane #(
    parameter int DATA_WIDTH = 10
) (
    input  logic [1:0]            sel,
    input  logic [9:0]            code,
    input  logic [DATA_WIDTH-1:0] pix,
    output logic [DATA_WIDTH-1:0] word
);
    // 10-bit codes are left-aligned, LSBs padded with zeros
    always_comb begin
        case (sel)
            2'd1:    word = '1;
            2'd2:    word = pix;
            default: word = DATA_WIDTH'(code) << (DATA_WIDTH - 10);
        endcase
    end
endmodule

module sonyimx_sync_sequencer #(
    parameter int         DATA_WIDTH  = 10,
    parameter int         CHANNEL_NUM = 8,
    parameter logic [9:0] BLANK_CODE  = 10'h040
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_enable,
    input  logic [15:0]                       iv_h_active,
    input  logic [15:0]                       iv_h_blank,
    input  logic [15:0]                       iv_v_active,
    input  logic [15:0]                       iv_v_blank,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    output logic                              o_pix_rd,
    output logic                              o_clk_en,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic                              o_fval,
    output logic                              o_lval
);
    localparam int            WW     = $clog2(DATA_WIDTH);
    localparam logic [WW-1:0] W_LAST = WW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] W_PRE  = WW'(DATA_WIDTH - 2);
    localparam logic [1:0]    SEL_CODE = 2'd0, SEL_ONES = 2'd1, SEL_PIX = 2'd2;

    typedef enum logic [2:0] {ST_IDLE, ST_SAV, ST_ACTIVE, ST_EAV, ST_HBLANK} state_t;
    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_blank;
        logic [15:0] v_active;
        logic [15:0] v_blank;
    } cfg_t;

    logic [WW-1:0] wcnt;
    logic          slot;
    state_t        cur_st, nxt_st;
    logic [15:0]   cur_cnt, nxt_cnt, cur_line, nxt_line;
    cfg_t          cfg;
    logic          eol, last_line, nxt_valid, fval_n, lval_n, new_frame;
    logic [1:0]    word_sel;
    logic [9:0]    word_code;
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] lane_pix, lane_word;

    assign slot      = (wcnt == W_LAST);
    assign last_line = ({1'b0, cur_line} + 17'd1) >= ({1'b0, cfg.v_active} + {1'b0, cfg.v_blank});

    // Registers hold the slot currently on the bus; nxt_* describes the slot loaded at the next boundary
    always_comb begin
        nxt_st   = cur_st;
        nxt_cnt  = cur_cnt + 16'd1;
        nxt_line = cur_line;
        eol      = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                nxt_cnt  = '0;
                nxt_line = '0;
                if (i_enable) nxt_st = ST_SAV;
            end
            ST_SAV: if (cur_cnt == 16'd3) begin
                nxt_st  = ST_ACTIVE;
                nxt_cnt = '0;
            end
            ST_ACTIVE: if (cur_cnt == cfg.h_active - 16'd1) begin
                nxt_st  = ST_EAV;
                nxt_cnt = '0;
            end
            ST_EAV: if (cur_cnt == 16'd3) begin
                nxt_cnt = '0;
                if (cfg.h_blank != 16'd0) nxt_st = ST_HBLANK;
                else                      eol    = 1'b1;
            end
            ST_HBLANK: if (cur_cnt == cfg.h_blank - 16'd1) begin
                nxt_cnt = '0;
                eol     = 1'b1;
            end
            default: begin
                nxt_st  = ST_IDLE;
                nxt_cnt = '0;
            end
        endcase
        // frame end only consults i_enable, so a dropped enable never cuts a frame short
        if (eol) begin
            if (!last_line) begin
                nxt_st   = ST_SAV;
                nxt_line = cur_line + 16'd1;
            end else begin
                nxt_st   = i_enable ? ST_SAV : ST_IDLE;
                nxt_line = '0;
            end
        end
    end

    assign new_frame = (nxt_st == ST_SAV) && (nxt_cnt == 16'd0) && (nxt_line == 16'd0);
    assign nxt_valid = (nxt_line == 16'd0) || (nxt_line < cfg.v_active);
    assign lval_n    = (nxt_st == ST_ACTIVE) && nxt_valid;
    assign fval_n    = (nxt_st != ST_IDLE) && nxt_valid &&
                       !((nxt_st == ST_HBLANK) && (nxt_line == cfg.v_active - 16'd1));

    always_comb begin
        word_sel  = SEL_CODE;
        word_code = BLANK_CODE;
        case (nxt_st)
            ST_SAV, ST_EAV: begin
                case (nxt_cnt[1:0])
                    2'd0:    word_sel  = SEL_ONES;
                    2'd3:    word_code = (nxt_st == ST_SAV) ? (nxt_valid ? 10'h200 : 10'h2AC)
                                                            : (nxt_valid ? 10'h274 : 10'h2D8);
                    default: word_code = 10'h000;
                endcase
            end
            ST_ACTIVE: if (nxt_valid) word_sel = SEL_PIX;
            default: ;
        endcase
    end

    for (genvar n = 0; n < CHANNEL_NUM; n++) begin : g_lane
`ifdef SONYIMX_TEST_PATTERN_EN
        assign lane_pix[n] = DATA_WIDTH'(nxt_cnt) + DATA_WIDTH'(n);
`else
        assign lane_pix[n] = iv_pix_data[n*DATA_WIDTH +: DATA_WIDTH];
`endif
        sonyimx_sync_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .sel  (word_sel),
            .code (word_code),
            .pix  (lane_pix[n]),
            .word (lane_word[n])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt     <= '0;
            o_clk_en <= 1'b0;
        end else begin
            wcnt     <= slot ? '0 : wcnt + 1'b1;
            o_clk_en <= slot;
        end
    end

`ifdef SONYIMX_TEST_PATTERN_EN
    assign o_pix_rd = 1'b0;
`else
    // read strobe leads the load by one clk so the show-ahead word is captured as upstream advances
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_pix_rd <= 1'b0;
        else          o_pix_rd <= (wcnt == W_PRE) && lval_n;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_st      <= ST_IDLE;
            cur_cnt     <= '0;
            cur_line    <= '0;
            cfg         <= '0;
            ov_pix_data <= '0;
            o_fval      <= 1'b0;
            o_lval      <= 1'b0;
        end else if (slot) begin
            cur_st      <= nxt_st;
            cur_cnt     <= nxt_cnt;
            cur_line    <= nxt_line;
            ov_pix_data <= lane_word;
            o_fval      <= fval_n;
            o_lval      <= lval_n;
            if (new_frame) cfg <= '{iv_h_active, iv_h_blank, iv_v_active, iv_v_blank};
        end
    end
endmodule

// File: tb/tb_sonyimx_sync_sequencer.sv
// Directed bench for sonyimx_sync_sequencer: per-slot scoreboard of word/fval/lval plus read-strobe accounting.
module tb_sonyimx_sync_sequencer;
    localparam int DW = 10;
    localparam int CH = 8;
    localparam int PW = DW * CH;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          fval;
        logic          lval;
    } slot_t;

    logic          clk, reset_n, i_enable;
    logic [15:0]   iv_h_active, iv_h_blank, iv_v_active, iv_v_blank;
    logic [PW-1:0] iv_pix_data, ov_pix_data;
    logic          o_pix_rd, o_clk_en, o_fval, o_lval;

    slot_t sb[$];
    int    n_cmp = 0, n_fail = 0;
    int    pix_ctr = 0, exp_pix = 0, rd_total = 0, rd_bad = 0, rd0 = 0;
    logic  rd_prev = 1'b0;

    sonyimx_sync_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable),
        .iv_h_active(iv_h_active), .iv_h_blank(iv_h_blank),
        .iv_v_active(iv_v_active), .iv_v_blank(iv_v_blank),
        .iv_pix_data(iv_pix_data), .o_pix_rd(o_pix_rd), .o_clk_en(o_clk_en),
        .ov_pix_data(ov_pix_data), .o_fval(o_fval), .o_lval(o_lval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] src_bus(input int k);
        logic [PW-1:0] b;
        for (int n = 0; n < CH; n++) b[n*DW +: DW] = DW'(k * 8 + n + 5);
        return b;
    endfunction

    function automatic logic [PW-1:0] fill(input logic [9:0] c);
        logic [PW-1:0] b;
        for (int n = 0; n < CH; n++) b[n*DW +: DW] = c;
        return b;
    endfunction

    function automatic int exp_rd(input int n);
`ifdef SONYIMX_TEST_PATTERN_EN
        return 0 * n;
`else
        return n;
`endif
    endfunction

    // upstream show-ahead source: advances on each clk edge that carries a read strobe
    assign iv_pix_data = src_bus(pix_ctr);
    always @(posedge clk) if (o_pix_rd) begin
        pix_ctr  <= pix_ctr + 1;
        rd_total <= rd_total + 1;
    end
    always @(negedge clk) begin
        if (rd_prev && !o_clk_en) rd_bad <= rd_bad + 1;
        rd_prev <= o_pix_rd;
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [PW-1:0] d, input logic f, input logic l);
        slot_t s;
        s.data = d; s.fval = f; s.lval = l;
        sb.push_back(s);
    endtask

    function automatic logic [PW-1:0] pix_word(input int idx);
        logic [PW-1:0] b;
`ifdef SONYIMX_TEST_PATTERN_EN
        for (int n = 0; n < CH; n++) b[n*DW +: DW] = DW'(idx + n);
`else
        b = src_bus(exp_pix + 0 * idx);
`endif
        return b;
    endfunction

    task automatic push_line(input int line, input int ha, input int hb, input int va);
        logic v, lastv;
        v = (line < va);
        lastv = (line == va - 1);
        push(fill(10'h3FF), v, 1'b0);
        push(fill(10'h000), v, 1'b0);
        push(fill(10'h000), v, 1'b0);
        push(fill(v ? 10'h200 : 10'h2AC), v, 1'b0);
        for (int i = 0; i < ha; i++) begin
            if (v) begin
                push(pix_word(i), 1'b1, 1'b1);
`ifndef SONYIMX_TEST_PATTERN_EN
                exp_pix++;
`endif
            end else push(fill(10'h040), 1'b0, 1'b0);
        end
        push(fill(10'h3FF), v, 1'b0);
        push(fill(10'h000), v, 1'b0);
        push(fill(10'h000), v, 1'b0);
        push(fill(v ? 10'h274 : 10'h2D8), v, 1'b0);
        for (int i = 0; i < hb; i++) push(fill(10'h040), v && !lastv, 1'b0);
    endtask

    task automatic push_frame(input int ha, input int hb, input int va, input int vb);
        for (int l = 0; l < va + vb; l++) push_line(l, ha, hb, va);
    endtask

    task automatic wait_slot(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!o_clk_en && gap < 40);
        chk("clk_en_seen", PW'(o_clk_en), PW'(1'b1));
    endtask

    task automatic check_slot();
        int    g;
        slot_t e;
        wait_slot(g);
        chk("clk_en_period", PW'(g), PW'(DW));
        if (sb.size() == 0) begin
            chk("sb_nonempty", PW'(0), PW'(1));
        end else begin
            e = sb.pop_front();
            chk("pix_data", ov_pix_data, e.data);
            chk("fval", PW'(o_fval), PW'(e.fval));
            chk("lval", PW'(o_lval), PW'(e.lval));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            check_slot();
            guard++;
        end
    endtask

    task automatic start(input int ha, input int hb, input int va, input int vb);
        iv_h_active = 16'(ha); iv_h_blank = 16'(hb);
        iv_v_active = 16'(va); iv_v_blank = 16'(vb);
        i_enable = 1'b1;
        rd0 = rd_total;
    endtask

    initial begin
        int g;
        reset_n = 1'b0; i_enable = 1'b0;
        iv_h_active = '0; iv_h_blank = '0; iv_v_active = '0; iv_v_blank = '0;

        // reset and idle
        repeat (25) @(negedge clk);
        chk("reset_outputs", PW'({ov_pix_data, o_clk_en, o_pix_rd, o_fval, o_lval}), '0);
        reset_n = 1'b1;
        wait_slot(g);
        push(fill(10'h040), 1'b0, 1'b0);
        push(fill(10'h040), 1'b0, 1'b0);
        drain();
        chk("idle_no_rd", PW'(rd_total), PW'(0));

        // single valid line + one vblank line, enable dropped mid-frame
        start(4, 2, 1, 1);
        push_frame(4, 2, 1, 1);
        check_slot();
        i_enable = 1'b0;
        drain();
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        chk("rd_count_t2", PW'(rd_total - rd0), PW'(exp_rd(4)));

        // enable drop during line 1 with a mid-frame h_active change
        start(3, 1, 3, 1);
        push_frame(3, 1, 3, 1);
        repeat (14) check_slot();
        i_enable = 1'b0;
        iv_h_active = 16'd5;
        drain();
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        chk("rd_count_t4a", PW'(rd_total - rd0), PW'(exp_rd(9)));
        start(5, 1, 3, 1);
        push_frame(5, 1, 3, 1);
        check_slot();
        i_enable = 1'b0;
        drain();
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        chk("rd_count_t4b", PW'(rd_total - rd0), PW'(exp_rd(15)));

        // asynchronous reset in the middle of ACTIVE
        start(8, 0, 1, 0);
        push_frame(8, 0, 1, 0);
        repeat (6) check_slot();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", PW'({ov_pix_data, o_clk_en, o_pix_rd, o_fval, o_lval}), '0);
        rd0 = rd_total;
        i_enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_rd_in_reset", PW'(rd_total), PW'(rd0));
        sb.delete();
        exp_pix = pix_ctr;
        reset_n = 1'b1;
        wait_slot(g);
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        start(2, 0, 1, 0);
        push_frame(2, 0, 1, 0);
        check_slot();
        i_enable = 1'b0;
        drain();
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        chk("rd_count_t5", PW'(rd_total - rd0), PW'(exp_rd(2)));

        // back-to-back frames with no blanking at all
        start(2, 0, 2, 0);
        push_frame(2, 0, 2, 0);
        push_frame(2, 0, 2, 0);
        repeat (21) check_slot();
        i_enable = 1'b0;
        drain();
        push(fill(10'h040), 1'b0, 1'b0);
        check_slot();
        chk("rd_count_t6", PW'(rd_total - rd0), PW'(exp_rd(8)));

        chk("rd_before_clk_en", PW'(rd_bad), PW'(0));
        chk("sb_drained", PW'(sb.size()), PW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sonyimx_sync_sequencer.md
Name: sonyimx_sync_sequencer

Overview:
Frame/line timing controller for the Sony IMX sensor simulation model. It drives the parallel word bus and the per-word load strobe of the sub-LVDS serializer. Each line is built as SAV sync code, active pixel words, EAV sync code and horizontal blanking, repeated over valid and vertical-blank lines. Pixel words are pulled from an upstream source through a read strobe.

Parameters:
DATA_WIDTH, 10, bits per lane word; must be >= 10.
CHANNEL_NUM, 8, number of lanes; all lanes carry identical sync/blank codes.
BLANK_CODE, 10'h040, filler word for blanking slots, left-aligned in DATA_WIDTH.

Ports:
clk  in  1  serial bit clock, same clock as the serializer.
reset_n  in  1  asynchronous, active-low reset.
i_enable  in  1  start/continue frame generation.
iv_h_active  in  16  active words per line per lane; must be >= 1.
iv_h_blank  in  16  blanking words per line after EAV; 0 allowed.
iv_v_active  in  16  valid lines per frame; must be >= 1.
iv_v_blank  in  16  vertical-blank lines per frame; 0 allowed.
iv_pix_data  in  DATA_WIDTH*CHANNEL_NUM  upstream pixels; show-ahead, valid whenever o_pix_rd is sampled.
o_pix_rd  out  1  one-clk read strobe; upstream advances on clk edge with o_pix_rd=1.
o_clk_en  out  1  serializer load strobe.
ov_pix_data  out  DATA_WIDTH*CHANNEL_NUM  parallel word to serializer.
o_fval  out  1  high from SAV of the first valid line through EAV of the last valid line.
o_lval  out  1  high during active-word slots of valid lines.

Behaviour:
- Reset (reset_n=0, async): all outputs 0, word counter 0, FSM in IDLE, all line/word counters 0.
- Word timing: a divide-by-DATA_WIDTH counter runs continuously after reset. o_clk_en=1 for exactly one clk every DATA_WIDTH clks. ov_pix_data updates on the edge where o_clk_en rises and holds for DATA_WIDTH clks. One FSM step occurs per word slot.
- Config: iv_* are latched at the first SAV slot of each frame. Changes mid-frame take effect at the next frame.
- FSM states: IDLE, SAV, ACTIVE, EAV, HBLANK.
  - IDLE: output BLANK_CODE; enter SAV at the next slot boundary when i_enable=1.
  - SAV: 4 slots: all-ones, 0, 0, XY.
  - ACTIVE: h_active slots.
  - EAV: 4 slots: all-ones, 0, 0, XY.
  - HBLANK: h_blank slots; skipped when h_blank=0.
  - At the end of a line: SAV if the frame is not finished, else the frame-end rule below.
- XY codes, 10-bit, left-aligned with zero LSB padding: valid line SAV 10'h200, EAV 10'h274; vblank line SAV 10'h2AC, EAV 10'h2D8.
- Line types: lines 0..v_active-1 are valid; lines v_active..v_active+v_blank-1 are vblank.
- ACTIVE slot content: valid lines output iv_pix_data; vblank lines output BLANK_CODE on all lanes.
- o_pix_rd: pulses 1 clk, one clk before o_clk_en, only for ACTIVE slots of valid lines. Exactly h_active pulses per valid line.
- Frame end: after the last line's HBLANK (or EAV if h_blank=0):
  - i_enable=1: start the next frame at SAV, with no gap.
  - i_enable=0: go to IDLE.
  - Deasserting i_enable mid-frame never truncates a frame.
- Counter widths: 16-bit counters, no wrap within legal config.
- Reset mid-frame: immediate return to reset state; the next enable starts a fresh frame at line 0.

Optional Feature:
Macro SONYIMX_TEST_PATTERN_EN.
- Defined: iv_pix_data is ignored and o_pix_rd is held 0. Valid-line ACTIVE slots output a ramp: lane n word = (pixel index within line + n) mod 2^DATA_WIDTH, with pixel index reset to 0 at each SAV.
- Undefined: upstream data path as above; no ramp logic.

Test Plan:
1. Reset/idle: hold reset_n=0, then release with i_enable=0 → outputs 0 during reset; after release o_clk_en pulses every 10 clks, ov_pix_data=BLANK_CODE on all lanes, o_pix_rd never asserted.
2. Single line structure: h_active=4, h_blank=2, v_active=1, v_blank=1, enable → valid line words 3FF,000,000,200, 4 pixels, 3FF,000,000,274, 040,040; exactly 4 o_pix_rd pulses; o_lval high for 4 slots.
3. Vblank line: continue test 2 → second line SAV XY=2AC, EAV XY=2D8, active slots 040, zero o_pix_rd; o_fval low through the vblank line.
4. Enable drop mid-frame: v_active=3, deassert i_enable during line 1 → lines 1..3 complete, then IDLE with no partial line; config change of h_active during a frame applies only to the next frame.
5. Async reset mid-ACTIVE: assert reset_n=0 mid-slot → outputs 0 immediately, with no further o_pix_rd; re-enable → frame restarts at line 0 SAV.
6. Boundary: h_blank=0, v_blank=0, back-to-back frames → EAV is followed directly by SAV, and line counter wraps 0..v_active-1 with no extra slots. With SONYIMX_TEST_PATTERN_EN defined, lane 3 first active word = 3.
